surf_dout_arbiter: RTL and testbench
====================================

# surf_dout_arbiter

Packet-level round-robin arbiter merging the seven per-SURF 8-bit AXI4-Stream data outputs (sysclk domain) into one stream for the downstream TURF event path. Grants one SURF at a time, passes its packet through unchanged until `tlast`, and tags every output byte with the source index. An optional stall watchdog aborts stuck packets and quarantines the offending SURF until software clears it.

## Interface

Parameters:
- `COUNT_WIDTH`, 16: width of each per-SURF packet counter.
- `TIMEOUT_CYCLES`, 1024: mid-packet stall limit in sysclk cycles; used only with `SURF_ARB_TIMEOUT_EN`; must be ≥ 2.

Ports:
- `sysclk_i`  in  1  system clock; all logic in this domain.
- `sysclk_rst_i`  in  1  synchronous, active-high reset.
- `s_tdata`  in  56  SURF n byte at `[8n +: 8]`, n = 0..6.
- `s_tvalid`  in  7  per-SURF valid.
- `s_tlast`  in  7  per-SURF end of packet.
- `s_tready`  out  7  per-SURF ready.
- `enable_i`  in  7  per-SURF arbitration enable (from the register core).
- `m_tdata`  out  8  merged byte.
- `m_tvalid`  out  1  merged valid.
- `m_tlast`  out  1  merged end of packet.
- `m_tuser`  out  4  `{abort, src[2:0]}`.
- `m_tready`  in  1  downstream ready.
- `busy_o`  out  1  high when not in IDLE.
- `pkt_count_o`  out  7×COUNT_WIDTH  completed-packet count, SURF n at `[COUNT_WIDTH*n +: COUNT_WIDTH]`.
- `timeout_o`  out  7  sticky per-SURF quarantine flag; constant 0 without the macro.
- `timeout_clr_i`  in  7  per-SURF quarantine clear.

## Operation

- States: IDLE, PASS, ABORT. ABORT exists only with the macro.
- Eligibility: SURF n is eligible when `enable_i[n] & s_tvalid[n] & ~timeout_o[n]`.
- IDLE:
  - Search eligible SURFs starting at `last+1` (mod 7) and register the first found as `grant`. Next state is PASS.
  - If none is eligible, stay in IDLE.
  - `s_tready` = `timeout_o`, so quarantined SURFs drain and discard. All other `s_tready` bits are 0. `m_tvalid` = 0.
- PASS (combinational pass-through of `grant`):
  - `m_tdata` = `s_tdata[grant]`, `m_tvalid` = `s_tvalid[grant]`, `m_tlast` = `s_tlast[grant]`.
  - `s_tready[grant]` = `m_tready`. Other bits are 0, or 1 where `timeout_o` is set (drain).
- PASS exit: on a handshake with `s_tlast[grant]` = 1:
  - next state is IDLE;
  - `last` <= `grant`;
  - `pkt_count[grant]` increments and wraps from all-ones to 0.
- Enable masking applies only at the IDLE search. Deasserting `enable_i[grant]` mid-packet does not truncate the packet.
- `m_tuser[2:0]` = `grant`, registered at grant time. `m_tuser[3]` is 0 in PASS.
- Reset, including mid-packet: go to IDLE, `last` = 6 (SURF 0 has first priority), counters = 0, `timeout_o` = 0. Any partial output packet is abandoned.

## Timing

- Reset values: `m_tvalid` 0, `m_tlast` 0, `m_tdata` 0, `m_tuser` 0, `s_tready` 0, `busy_o` 0, `pkt_count_o` 0, `timeout_o` 0.
- Grant latency: an eligible `tvalid` sampled in IDLE gives PASS on the next cycle. The first byte can be accepted that cycle, one cycle after `tvalid` rises.
- Packet gap: exactly one IDLE cycle between consecutive packets, even if the same or another SURF is waiting.
- Pass-through adds zero latency. AXI stability holds because sources are AXI-compliant and `grant` is stable throughout PASS.
- Single-byte packets (`tlast` on the first byte) are legal: PASS lasts one cycle when `m_tready` = 1.
- `pkt_count_o` updates the cycle after the `tlast` handshake.

## Configuration

- `SURF_ARB_TIMEOUT_EN` defined:
  - Stall counter: clears on entry to PASS and on any cycle with `s_tvalid[grant]` = 1. Otherwise it increments in PASS.
  - When the counter equals `TIMEOUT_CYCLES-1` and `s_tvalid[grant]` = 0, the next state is ABORT.
  - ABORT: all `s_tready` = 0 except quarantined bits. Output `m_tvalid` = 1, `m_tdata` = 0x00, `m_tlast` = 1, `m_tuser` = `{1, grant}`, held until `m_tready`.
  - On that handshake: state goes to IDLE, `timeout_o[grant]` sets, `last` <= `grant`, and `pkt_count` does not increment.
  - `timeout_clr_i[n]` clears `timeout_o[n]`. A set and clear in the same cycle: set wins.
- Not defined: no ABORT state and no stall counter. PASS waits indefinitely. `timeout_o` is tied to 0 and `timeout_clr_i` is ignored.

## Test plan

- Reset, then SURF 2 sends 3 bytes `AA BB CC` with `tlast` on `CC`, `m_tready` = 1 → output `AA BB CC`, `m_tuser` = 2 on each byte, `tlast` only on `CC`, `pkt_count[2]` = 1, `busy_o` falls the next cycle.
- SURFs 0, 3 and 6 all hold 2-byte packets continuously → grant order 0, 3, 6, 0…, exactly one idle cycle between packets.
- `enable_i[1]` cleared mid-packet from SURF 1 → packet completes. A new SURF 1 packet is not granted while the bit is low; SURF 4 is still served.
- `m_tready` toggled 1,0,1,0 during a SURF 5 packet → no byte lost or duplicated, and `m_tdata` is stable whenever `m_tvalid & ~m_tready`.
- (`SURF_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16) SURF 3 sends 1 byte without `tlast`, then drops `tvalid` → after 16 stall cycles, output byte `00` with `tlast` and `m_tuser` = 0xB. `timeout_o[3]` = 1, later SURF 3 bytes are drained, and `timeout_clr_i[3]` restores arbitration.
- `pkt_count[0]` preloaded to 0xFFFF via 65535 packets → the next packet wraps it to 0. Reset asserted mid-packet → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/surf_dout_arbiter.sv
// ---------------------------------------------------------------------------
// surf_dout_arbiter
//
// Packet-level round-robin arbiter that merges the seven per-SURF 8-bit
// AXI4-Stream outputs into a single stream for the TURF event path. One SURF
// is granted at a time and its packet is passed through combinationally,
// unchanged, until tlast. Every output byte carries the source index on
// m_tuser[2:0].
//
// Optional feature (compile-time macro SURF_ARB_TIMEOUT_EN):
//   A mid-packet stall watchdog. If the granted SURF stops presenting data
//   for TIMEOUT_CYCLES cycles, the packet is closed with a single 0x00 byte
//   flagged by m_tuser[3], and that SURF is quarantined (its bytes are drained
//   and discarded) until software pulses timeout_clr_i for it.
//   Without the macro there is no ABORT state, timeout_o is tied to 0 and
//   timeout_clr_i is ignored.
//
// Ports:
//   sysclk_i       in   1          system clock, all logic in this domain
//   sysclk_rst_i   in   1          synchronous active-high reset
//   s_tdata        in   56         SURF n byte at [8n +: 8]
//   s_tvalid       in   7          per-SURF valid
//   s_tlast        in   7          per-SURF end of packet
//   s_tready       out  7          per-SURF ready
//   enable_i       in   7          per-SURF arbitration enable
//   m_tdata        out  8          merged byte
//   m_tvalid       out  1          merged valid
//   m_tlast        out  1          merged end of packet
//   m_tuser        out  4          {abort, src[2:0]}
//   m_tready       in   1          downstream ready
//   busy_o         out  1          high whenever the arbiter is not idle
//   pkt_count_o    out  7*CW       completed-packet counters, SURF n at [CW*n +: CW]
//   timeout_o      out  7          sticky per-SURF quarantine flags
//   timeout_clr_i  in   7          per-SURF quarantine clear
// ---------------------------------------------------------------------------
module surf_dout_arbiter #(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       sysclk_i,
    input  logic                       sysclk_rst_i,
    input  logic [55:0]                s_tdata,
    input  logic [6:0]                 s_tvalid,
    input  logic [6:0]                 s_tlast,
    output logic [6:0]                 s_tready,
    input  logic [6:0]                 enable_i,
    output logic [7:0]                 m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    output logic [3:0]                 m_tuser,
    input  logic                       m_tready,
    output logic                       busy_o,
    output logic [7*COUNT_WIDTH-1:0]   pkt_count_o,
    output logic [6:0]                 timeout_o,
    input  logic [6:0]                 timeout_clr_i
);

    localparam int NUM_SURF = 7;

`ifdef SURF_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1
    } state_t;
`endif

    // Round-robin search: first eligible SURF strictly after 'last', modulo 7.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [6:0] elig, input logic [2:0] last);
        logic [3:0] result;
        logic [2:0] idx;
        int         pos;
        result = 4'd0;
        for (int i = 1; i <= NUM_SURF; i++) begin
            pos = (int'(last) + i) % NUM_SURF;
            idx = 3'(pos);
            if ((result[3] == 1'b0) && (elig[idx] == 1'b1)) begin
                result = {1'b1, idx};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [2:0]             grant_r;
    logic [2:0]             last_r;
    logic [COUNT_WIDTH-1:0] pkt_count_r [NUM_SURF];

    logic [6:0]             timeout_s;
    logic [6:0]             elig_s;
    logic [3:0]             pick_s;
    logic [7:0]             g_data_s;
    logic                   g_valid_s;
    logic                   g_last_s;
    logic                   pass_done_s;

    assign elig_s      = enable_i & s_tvalid & ~timeout_s;
    assign pick_s      = rr_pick(elig_s, last_r);
    assign g_valid_s   = s_tvalid[grant_r];
    assign g_last_s    = s_tlast[grant_r];
    assign pass_done_s = (state_r == ST_PASS) && g_valid_s && m_tready && g_last_s;
    assign busy_o      = (state_r != ST_IDLE);
    assign timeout_o   = timeout_s;

    // Byte mux for the granted SURF.
    always_comb begin
        g_data_s = 8'h00;
        case (grant_r)
            3'd0:    g_data_s = s_tdata[7:0];
            3'd1:    g_data_s = s_tdata[15:8];
            3'd2:    g_data_s = s_tdata[23:16];
            3'd3:    g_data_s = s_tdata[31:24];
            3'd4:    g_data_s = s_tdata[39:32];
            3'd5:    g_data_s = s_tdata[47:40];
            3'd6:    g_data_s = s_tdata[55:48];
            default: g_data_s = 8'h00;
        endcase
    end

`ifdef SURF_ARB_TIMEOUT_EN
    // TIMEOUT_CYCLES >= 2, so the compare value TIMEOUT_CYCLES-1 fits here.
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] stall_cnt_r;
    logic [6:0]         timeout_r;
    logic [6:0]         timeout_set_s;
    logic               stall_hit_s;
    logic               abort_done_s;

    assign stall_hit_s   = (stall_cnt_r == STALL_W'(TIMEOUT_CYCLES - 1)) && !g_valid_s;
    assign abort_done_s  = (state_r == ST_ABORT) && m_tready;
    assign timeout_set_s = abort_done_s ? (7'd1 << grant_r) : 7'd0;
    assign timeout_s     = timeout_r;

    // Stall counter: counts consecutive PASS cycles with no valid from the
    // granted SURF; held at zero outside PASS so each grant starts fresh.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if ((state_r == ST_PASS) && !g_valid_s) begin
            stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end else begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end
    end

    // Sticky quarantine flags; a set on the abort handshake beats a clear.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            timeout_r <= 7'd0;
        end else begin
            timeout_r <= (timeout_r & ~timeout_clr_i) | timeout_set_s;
        end
    end
`else
    logic unused_clr_s;

    assign unused_clr_s = ^timeout_clr_i;
    assign timeout_s    = 7'd0;
`endif

    // Next-state and output decode. Quarantined SURFs always see tready so
    // they drain; the granted SURF sees the downstream ready only in PASS.
    always_comb begin
        state_nxt_s = state_r;
        m_tdata     = 8'h00;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tuser     = 4'h0;
        s_tready    = timeout_s;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                m_tdata           = g_data_s;
                m_tvalid          = g_valid_s;
                m_tlast           = g_last_s;
                m_tuser           = {1'b0, grant_r};
                s_tready[grant_r] = m_tready;
                if (pass_done_s) begin
                    state_nxt_s = ST_IDLE;
`ifdef SURF_ARB_TIMEOUT_EN
                end else if (stall_hit_s) begin
                    state_nxt_s = ST_ABORT;
`endif
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
`ifdef SURF_ARB_TIMEOUT_EN
            ST_ABORT: begin
                // Close the truncated packet with one flagged filler byte.
                m_tdata  = 8'h00;
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tuser  = {1'b1, grant_r};
                if (m_tready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, grant latch and round-robin pointer. Reset leaves
    // last_r at 6 so SURF 0 has first priority.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            state_r <= ST_IDLE;
            grant_r <= 3'd0;
            last_r  <= 3'd6;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && pick_s[3]) begin
                grant_r <= pick_s[2:0];
            end
            if (pass_done_s) begin
                last_r <= grant_r;
`ifdef SURF_ARB_TIMEOUT_EN
            end else if (abort_done_s) begin
                last_r <= grant_r;
`endif
            end
        end
    end

    // Completed-packet counters; aborted packets are not counted. Wraps.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            for (int n = 0; n < NUM_SURF; n++) begin
                pkt_count_r[n] <= {COUNT_WIDTH{1'b0}};
            end
        end else if (pass_done_s) begin
            pkt_count_r[grant_r] <= pkt_count_r[grant_r] + COUNT_WIDTH'(1);
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        pkt_count_o = {(7 * COUNT_WIDTH){1'b0}};
        for (int n = 0; n < NUM_SURF; n++) begin
            pkt_count_o[COUNT_WIDTH*n +: COUNT_WIDTH] = pkt_count_r[n];
        end
    end

endmodule

// File: tb/tb_surf_dout_arbiter.sv
// Self-checking bench for surf_dout_arbiter. Seven source models replay
// per-SURF byte queues; expected output beats go into a scoreboard queue as
// stimulus is loaded and are popped on each output handshake.
module tb_surf_dout_arbiter;

    localparam int CW = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [55:0]    s_tdata;
    logic [6:0]     s_tvalid;
    logic [6:0]     s_tlast;
    logic [6:0]     s_tready;
    logic [6:0]     enable_i;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tlast;
    logic [3:0]     m_tuser;
    logic           m_tready;
    logic           busy_o;
    logic [7*CW-1:0] pkt_count_o;
    logic [6:0]     timeout_o;
    logic [6:0]     timeout_clr_i;

    surf_dout_arbiter #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .sysclk_i      (clk),
        .sysclk_rst_i  (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .enable_i      (enable_i),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .m_tready      (m_tready),
        .busy_o        (busy_o),
        .pkt_count_o   (pkt_count_o),
        .timeout_o     (timeout_o),
        .timeout_clr_i (timeout_clr_i)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] user;
    } beat_t;

    typedef struct {
        logic [6:0] load;
        logic [6:0] en;
        logic [2:0] exp_src;
    } vec_t;

    beat_t      exp_q [$];
    logic [8:0] smem [7][256];
    int         wr_p [7];
    int         rd_p [7];
    int         exp_cnt [7];
    logic [6:0] quar = 7'd0;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int i);
        return pkt_count_o[CW*i +: CW];
    endfunction

    task automatic push_src(input int src, input logic [7:0] d, input logic last);
        smem[src][8'(wr_p[src])] = {last, d};
        wr_p[src]++;
    endtask

    task automatic expect_pkt(input int src, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({base + 8'(17 * i), (i == n - 1), {1'b0, 3'(src)}});
        end
    endtask

    task automatic send_pkt(input int src, input int n, input logic [7:0] base, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            push_src(src, base + 8'(17 * i), (i == n - 1));
        end
        if (expect_out) expect_pkt(src, n, base);
    endtask

    task automatic wait_sb(input int budget, input string nm, input int tail);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual_remaining=%0d required=0", nm, exp_q.size());
            exp_q.delete();
        end
        step(tail);
    endtask

    task automatic flush_srcs();
        for (int i = 0; i < 7; i++) rd_p[i] = wr_p[i];
    endtask

    task automatic quiesce();
        enable_i = 7'd0;
        step(2);
        flush_srcs();
        step(1);
    endtask

    task automatic check_reset(input string p);
        check({p, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({p, "_m_tlast"}, 32'(m_tlast), 32'd0);
        check({p, "_m_tdata"}, 32'(m_tdata), 32'd0);
        check({p, "_m_tuser"}, 32'(m_tuser), 32'd0);
        check({p, "_s_tready"}, 32'(s_tready), 32'd0);
        check({p, "_busy"}, 32'(busy_o), 32'd0);
        check({p, "_pkt_count"}, 32'(pkt_count_o), 32'd0);
        check({p, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    // Source models plus output monitor: sample at negedge, drive after posedge.
    initial begin : drv_mon
        logic [6:0] hs;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       idle_chk;
        logic       busy_chk;
        beat_t      b;
        s_tdata = 56'd0;
        s_tvalid = 7'd0;
        s_tlast = 7'd0;
        hs = 7'd0;
        prev_stall = 1'b0;
        prev_data = 8'd0;
        idle_chk = 1'b0;
        busy_chk = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            if (rst) begin
                prev_stall = 1'b0;
                idle_chk = 1'b0;
                busy_chk = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(m_tvalid), 32'd1);
                    check("hold_data", 32'(m_tdata), 32'(prev_data));
                end
                if (idle_chk) begin
                    check("gap_idle", 32'(busy_o), 32'd0);
                    busy_chk = |(enable_i & s_tvalid & ~quar);
                    idle_chk = 1'b0;
                end else if (busy_chk) begin
                    check("gap_regrant", 32'(busy_o), 32'd1);
                    busy_chk = 1'b0;
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected actual=0x%0h required=no_beat", {m_tdata, m_tlast, m_tuser});
                    end else begin
                        b = exp_q.pop_front();
                        check("sb_data", 32'(m_tdata), 32'(b.data));
                        check("sb_last", 32'(m_tlast), 32'(b.last));
                        check("sb_user", 32'(m_tuser), 32'(b.user));
                    end
                    if (m_tlast) idle_chk = 1'b1;
                end
                prev_stall = m_tvalid & ~m_tready;
                prev_data = m_tdata;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 7; i++) begin
                if (hs[i]) rd_p[i]++;
                if (rd_p[i] < wr_p[i]) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[8*i +: 8] = smem[i][8'(rd_p[i])][7:0];
                    s_tlast[i] = smem[i][8'(rd_p[i])][8];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdata[8*i +: 8] = 8'd0;
                    s_tlast[i] = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        vec_t vecs [9];
        int   r0;
        int   n;
        vecs[0] = '{7'b1111111, 7'b1111111, 3'd0};
        vecs[1] = '{7'b1111111, 7'b1111111, 3'd1};
        vecs[2] = '{7'b0101000, 7'b1111111, 3'd3};
        vecs[3] = '{7'b1000101, 7'b1111111, 3'd6};
        vecs[4] = '{7'b0000111, 7'b1111110, 3'd1};
        vecs[5] = '{7'b0000011, 7'b1111111, 3'd0};
        vecs[6] = '{7'b1000000, 7'b1000000, 3'd6};
        vecs[7] = '{7'b1111111, 7'b0010000, 3'd4};
        vecs[8] = '{7'b0011000, 7'b1111111, 3'd3};
        for (int i = 0; i < 7; i++) begin
            wr_p[i] = 0;
            rd_p[i] = 0;
            exp_cnt[i] = 0;
        end
        rst = 1'b1;
        enable_i = 7'd0;
        m_tready = 1'b0;
        timeout_clr_i = 7'd0;
        step(3);
        check_reset("rst_init");
        rst = 1'b0;
        m_tready = 1'b1;
        enable_i = 7'h7F;
        step(1);

        // SURF 2: AA BB CC
        send_pkt(2, 3, 8'hAA, 1'b1);
        exp_cnt[2]++;
        wait_sb(40, "t1", 2);
        check("t1_cnt2", 32'(cnt(2)), 32'd1);

        // SURFs 0/3/6 with two 2-byte packets each; last grant was 2 so 3 leads.
        for (int k = 0; k < 2; k++) begin
            send_pkt(3, 2, 8'h30 + 8'(k), 1'b1);
            send_pkt(6, 2, 8'h60 + 8'(k), 1'b1);
            send_pkt(0, 2, 8'h00 + 8'(k), 1'b1);
            exp_cnt[3]++;
            exp_cnt[6]++;
            exp_cnt[0]++;
        end
        wait_sb(80, "t2", 2);

        // Enable dropped mid-packet on SURF 1.
        r0 = rd_p[1];
        send_pkt(1, 4, 8'h10, 1'b1);
        n = 0;
        while (rd_p[1] == r0 && n < 20) begin
            step(1);
            n++;
        end
        check("t3_started", 32'(rd_p[1] > r0), 32'd1);
        enable_i[1] = 1'b0;
        send_pkt(1, 2, 8'h50, 1'b0);
        send_pkt(4, 2, 8'h40, 1'b1);
        exp_cnt[1]++;
        exp_cnt[4]++;
        wait_sb(60, "t3a", 0);
        repeat (4) begin
            step(1);
            check("t3_masked_idle", 32'(busy_o), 32'd0);
        end
        check("t3_pending", 32'(wr_p[1] - rd_p[1]), 32'd2);
        expect_pkt(1, 2, 8'h50);
        exp_cnt[1]++;
        enable_i[1] = 1'b1;
        wait_sb(40, "t3b", 2);

        // SURF 5 with m_tready toggling.
        send_pkt(5, 4, 8'h61, 1'b1);
        exp_cnt[5]++;
        for (int k = 0; k < 12; k++) begin
            m_tready = (k % 2 == 0);
            step(1);
        end
        m_tready = 1'b1;
        wait_sb(40, "t4", 2);
        for (int i = 0; i < 7; i++) check("cnt_pre", 32'(cnt(i)), 32'(exp_cnt[i]));

        // Reset in the middle of a stalled SURF 2 packet.
        m_tready = 1'b0;
        send_pkt(2, 4, 8'h70, 1'b0);
        n = 0;
        while (!busy_o && n < 10) begin
            step(1);
            n++;
        end
        check("rmid_busy", 32'(busy_o), 32'd1);
        check("rmid_valid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        flush_srcs();
        step(1);
        check_reset("rst_mid");
        step(1);
        rst = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 7; i++) exp_cnt[i] = 0;

        // Round-robin / enable table, starting from the reset pointer.
        for (int v = 0; v < 9; v++) begin
            quiesce();
            for (int i = 0; i < 7; i++) begin
                if (vecs[v].load[i]) push_src(i, 8'hD0 | 8'(i), 1'b1);
            end
            exp_q.push_back({8'hD0 | 8'(vecs[v].exp_src), 1'b1, {1'b0, vecs[v].exp_src}});
            exp_cnt[vecs[v].exp_src]++;
            enable_i = vecs[v].en;
            wait_sb(30, "vec", 0);
            enable_i = 7'd0;
        end
        quiesce();
        for (int i = 0; i < 7; i++) check("cnt_tab", 32'(cnt(i)), 32'(exp_cnt[i]));
        enable_i = 7'h7F;

        // Counter wrap on SURF 0.
        n = 15 - exp_cnt[0];
        for (int k = 0; k < n; k++) send_pkt(0, 1, 8'(k), 1'b1);
        wait_sb(200, "wrap_a", 2);
        check("wrap_full", 32'(cnt(0)), 32'd15);
        send_pkt(0, 1, 8'hEE, 1'b1);
        wait_sb(20, "wrap_b", 2);
        check("wrap_zero", 32'(cnt(0)), 32'd0);

`ifdef SURF_ARB_TIMEOUT_EN
        // SURF 3 stalls after one byte: abort, quarantine, drain, clear.
        push_src(3, 8'h5A, 1'b0);
        exp_q.push_back({8'h5A, 1'b0, 4'h3});
        exp_q.push_back({8'h00, 1'b1, 4'hB});
        wait_sb(100, "to_abort", 2);
        quar = 7'h08;
        check("to_flag", 32'(timeout_o), 32'h08);
        check("to_no_count", 32'(cnt(3)), 32'(exp_cnt[3]));
        send_pkt(3, 2, 8'h90, 1'b0);
        step(6);
        check("to_drained", 32'(wr_p[3] - rd_p[3]), 32'd0);
        check("to_idle", 32'(busy_o), 32'd0);
        timeout_clr_i = 7'h08;
        step(1);
        timeout_clr_i = 7'd0;
        quar = 7'd0;
        check("to_clear", 32'(timeout_o), 32'd0);
        send_pkt(3, 1, 8'h99, 1'b1);
        wait_sb(20, "to_restore", 2);
`else
        timeout_clr_i = 7'h7F;
        step(1);
        timeout_clr_i = 7'd0;
        check("timeout_tied", 32'(timeout_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
